section_min_max_extractor: RTL and testbench

- Upstream producer for the section min/max ring buffer.
- Consumes a stream of audio samples and splits it into consecutive sections of sample_count samples.
- For each section, emits one {min, max} pair over a valid/ready handshake.
- Values are emitted as unsigned offset-binary, so the downstream buffer's unsigned compares and max − min subtraction give the correct peak-to-peak.

---
 rtl/section_min_max_extractor.sv | 120 ++++++++++++
 tb/tb_section_min_max_extractor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/section_min_max_extractor.sv
// rtl/section_min_max_extractor.sv - per-section min/max extractor feeding the section ring buffer
// Emits one offset-binary {min, max} pair per sample_count accepted samples.
module section_min_max_extractor #(
  parameter int width        = 16,
  parameter int sample_count = 32,
  parameter bit is_signed    = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_value,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_min_value,
  output logic [width-1:0] o_max_value
);

  localparam int CW = (sample_count > 1) ? $clog2(sample_count) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(sample_count - 1);

  typedef enum logic {ACCUM, HOLD} state_e;

  function automatic logic [width-1:0] to_offset(input logic [width-1:0] v);
    if (is_signed) return {~v[width-1], v[width-2:0]};
    else           return v;
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [width-1:0]  acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [width-1:0]  out_min_q, out_min_d, out_max_q, out_max_d;
  logic              o_valid_q, o_valid_d, i_ready_q, i_ready_d;

  logic [width-1:0]  u, base_min, base_max, new_min, new_max;
  logic              in_xfer, out_xfer, is_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      acc_min_q <= '1;
      acc_max_q <= '0;
      out_min_q <= '1;
      out_max_q <= '0;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      out_min_q <= out_min_d;
      out_max_q <= out_max_d;
      o_valid_q <= o_valid_d;
      i_ready_q <= i_ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    out_min_d = out_min_q;
    out_max_d = out_max_q;
    o_valid_d = o_valid_q;
    i_ready_d = i_ready_q;

    in_xfer  = i_valid && i_ready_q;
    out_xfer = o_valid_q && o_ready;
    is_last  = (cnt_q == LAST_IDX);

    // The first sample of a section seeds both extremes, so stale accumulators never leak.
    u        = to_offset(i_value);
    base_min = (cnt_q == '0) ? '1 : acc_min_q;
    base_max = (cnt_q == '0) ? '0 : acc_max_q;
    new_min  = (u < base_min) ? u : base_min;
    new_max  = (u > base_max) ? u : base_max;

    unique case (state_q)
      ACCUM: begin
        if (out_xfer) o_valid_d = 1'b0;
        if (in_xfer) begin
          cnt_d = is_last ? '0 : cnt_q + CW'(1);
          if (!is_last) begin
            acc_min_d = new_min;
            acc_max_d = new_max;
          end else if (!o_valid_q || o_ready) begin
            out_min_d = new_min;
            out_max_d = new_max;
            o_valid_d = 1'b1;
          end else begin
            // Park the finished pair until the consumer frees the output slot.
            acc_min_d = new_min;
            acc_max_d = new_max;
            i_ready_d = 1'b0;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (o_ready) begin
          out_min_d = acc_min_q;
          out_max_d = acc_max_q;
          i_ready_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign i_ready     = i_ready_q;
  assign o_valid     = o_valid_q;
  assign o_min_value = out_min_q;
  assign o_max_value = out_max_q;

endmodule

// File: tb/tb_section_min_max_extractor.sv
// tb/tb_section_min_max_extractor.sv - scoreboard bench for section_min_max_extractor
// Three instances: signed/4, unsigned/4, signed/1.
module tb_section_min_max_extractor;

  localparam int W = 16;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]        iv, ir, ov, ord;
  logic [N-1:0][W-1:0] ival, omin, omax;

  section_min_max_extractor #(.width(W), .sample_count(4), .is_signed(1'b1)) dut0 (
    .clk(clk), .reset_n(rst_n), .i_valid(iv[0]), .i_ready(ir[0]), .i_value(ival[0]),
    .o_valid(ov[0]), .o_ready(ord[0]), .o_min_value(omin[0]), .o_max_value(omax[0]));
  section_min_max_extractor #(.width(W), .sample_count(4), .is_signed(1'b0)) dut1 (
    .clk(clk), .reset_n(rst_n), .i_valid(iv[1]), .i_ready(ir[1]), .i_value(ival[1]),
    .o_valid(ov[1]), .o_ready(ord[1]), .o_min_value(omin[1]), .o_max_value(omax[1]));
  section_min_max_extractor #(.width(W), .sample_count(1), .is_signed(1'b1)) dut2 (
    .clk(clk), .reset_n(rst_n), .i_valid(iv[2]), .i_ready(ir[2]), .i_value(ival[2]),
    .o_valid(ov[2]), .o_ready(ord[2]), .o_min_value(omin[2]), .o_max_value(omax[2]));

  function automatic int sc_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit sg_of(input int k);
    return (k != 1);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted samples per section, pair = plain min/max of offset values.
  logic [W-1:0] sec  [N][$];
  logic [31:0]  expq [N][$];
  logic         phold[N];
  logic [W-1:0] pmin [N], pmax[N];

  always @(negedge clk) begin : model
    logic [W-1:0] u, mn, mx;
    logic [31:0]  e;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        sec[k].delete();
        expq[k].delete();
        phold[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (phold[k]) begin
          check($sformatf("stable_valid%0d", k), 32'(ov[k]), 32'd1);
          check($sformatf("stable_pair%0d", k), {omin[k], omax[k]}, {pmin[k], pmax[k]});
        end
        if (ov[k]) check($sformatf("min_le_max%0d", k), 32'(omin[k] <= omax[k]), 32'd1);
        if (ov[k] && ord[k]) begin
          if (expq[k].size() == 0) begin
            check($sformatf("unexpected_pair%0d", k), {omin[k], omax[k]}, 32'hxxxxxxxx);
          end else begin
            e = expq[k].pop_front();
            check($sformatf("pair%0d", k), {omin[k], omax[k]}, e);
          end
        end
        if (iv[k] && ir[k]) begin
          u = sg_of(k) ? W'(ival[k] + 16'h8000) : ival[k];
          sec[k].push_back(u);
          if (sec[k].size() == sc_of(k)) begin
            mn = '1;
            mx = '0;
            foreach (sec[k][i]) begin
              if (sec[k][i] < mn) mn = sec[k][i];
              if (sec[k][i] > mx) mx = sec[k][i];
            end
            expq[k].push_back({mn, mx});
            sec[k].delete();
          end
        end
        phold[k] = ov[k] && !ord[k];
        pmin[k]  = omin[k];
        pmax[k]  = omax[k];
      end
    end
  end

  // Holds i_valid high; returns one tick after the edge at which the sample was accepted.
  task automatic push(input int k, input logic [W-1:0] v);
    iv[k]   = 1'b1;
    ival[k] = v;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ir[k]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL push_timeout dut%0d: i_ready stayed 0", k);
    iv[k] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  time t0;

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ord   = '0;
    ival  = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        check("rst_i_ready", 32'(ir[k]), 32'd1);
        check("rst_o_valid", 32'(ov[k]), 32'd0);
        check("rst_min_max", {omin[k], omax[k]}, 32'hFFFF_0000);
      end
    end
    rst_n = 1'b1;
    tick();

    // Signed, four samples spanning the full range.
    ord[0] = 1'b1;
    push(0, 16'h0001);
    push(0, 16'hFFFF);
    push(0, 16'h7FFF);
    check("s4_no_early_valid", 32'(ov[0]), 32'd0);
    push(0, 16'h8000);
    iv[0] = 1'b0;
    check("s4_valid", 32'(ov[0]), 32'd1);
    check("s4_pair", {omin[0], omax[0]}, 32'h0000_FFFF);
    tick();
    check("s4_one_cycle", 32'(ov[0]), 32'd0);

    // Unsigned, back-to-back sections; second must not inherit the first's max.
    ord[1] = 1'b1;
    push(1, 16'd100); push(1, 16'd200); push(1, 16'd150); push(1, 16'd120);
    check("u4_pair_a", {omin[1], omax[1]}, {16'd100, 16'd200});
    push(1, 16'd10); push(1, 16'd3); push(1, 16'd7); push(1, 16'd5);
    iv[1] = 1'b0;
    check("u4_pair_b", {omin[1], omax[1]}, {16'd3, 16'd10});
    tick();

    // Backpressure: second section parks while the first pair waits.
    ord[1] = 1'b0;
    push(1, 16'd50); push(1, 16'd60); push(1, 16'd40); push(1, 16'd70);
    push(1, 16'd9);  push(1, 16'd1);  push(1, 16'd8);  push(1, 16'd2);
    iv[1] = 1'b0;
    check("bp_i_ready_low", 32'(ir[1]), 32'd0);
    check("bp_valid", 32'(ov[1]), 32'd1);
    check("bp_pair_a", {omin[1], omax[1]}, {16'd40, 16'd70});
    ord[1] = 1'b1;
    tick();
    ord[1] = 1'b0;
    check("bp_valid_b", 32'(ov[1]), 32'd1);
    check("bp_i_ready_back", 32'(ir[1]), 32'd1);
    check("bp_pair_b", {omin[1], omax[1]}, {16'd1, 16'd9});
    ord[1] = 1'b1;
    tick();
    check("bp_drained", 32'(ov[1]), 32'd0);

    // sample_count = 1: every sample is a pair, no stall between them.
    ord[2] = 1'b1;
    push(2, 16'h1234);
    check("sc1_valid_a", 32'(ov[2]), 32'd1);
    check("sc1_pair_a", {omin[2], omax[2]}, 32'h9234_9234);
    t0 = $time;
    push(2, 16'hF000);
    iv[2] = 1'b0;
    check("sc1_no_stall", 32'($time - t0), 32'd10);
    check("sc1_pair_b", {omin[2], omax[2]}, 32'h7000_7000);
    tick();
    check("sc1_drained", 32'(ov[2]), 32'd0);

    // Reset mid-section discards the partial section.
    push(0, 16'h0011);
    push(0, 16'h0022);
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("mr_clear", 32'(ov[0]), 32'd0);
    for (int i = 0; i < 3; i++) push(0, 16'h0005);
    check("mr_no_early", 32'(ov[0]), 32'd0);
    push(0, 16'h0005);
    iv[0] = 1'b0;
    check("mr_valid", 32'(ov[0]), 32'd1);
    check("mr_pair", {omin[0], omax[0]}, 32'h8005_8005);
    tick();
    check("mr_single", 32'(ov[0]), 32'd0);

    // Random traffic on all three instances, checked by the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ord[k]  = ($urandom_range(0, 2) != 0);
        ival[k] = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000)
                                               : W'($urandom);
      end
      tick();
    end
    iv  = '0;
    ord = '1;
    for (int c = 0; c < 10; c++) tick();
    for (int k = 0; k < N; k++) begin
      check($sformatf("drain_empty%0d", k), 32'(expq[k].size()), 32'd0);
      check($sformatf("drain_valid%0d", k), 32'(ov[k]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
